unified_cache_crossbar: RTL and testbench
=========================================

UNIFIED_CACHE_CROSSBAR -- requirements
Module: unified_cache_crossbar

Interface
REQ-001 SHALL have parameter NUM_INPUT_PORT, default 2, number of requester ports.
REQ-002 SHALL have parameter NUM_BANK, default 4, number of cache banks; power of two, at least 2.
REQ-003 SHALL have parameter UNIFIED_CACHE_PACKET_WIDTH_IN_BITS, default `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS, packet width.
REQ-004 SHALL have parameter QUEUE_DEPTH, default 4, per-port input FIFO entries; power of two, at least 2.
REQ-005 SHALL have parameter BLOCK_OFFSET_WIDTH, default 6, address bits below the bank-select field.
REQ-006 SHALL have port clk_in, input, 1, the single clock.
REQ-007 SHALL have port reset_in, input, 1, reset; synchronous, active-high.
REQ-008 SHALL have port request_flatted_in, input, NUM_INPUT_PORT*W, requester packets; port p at slice [p*W +: W].
REQ-009 SHALL have port request_ack_flatted_out, input-ack output, NUM_INPUT_PORT, one-cycle capture pulse per port.
REQ-010 SHALL have port bank_request_flatted_out, output, NUM_BANK*W, registered packet per bank.
REQ-011 SHALL have port bank_request_ack_flatted_in, input, NUM_BANK, bank consumed its packet.
REQ-012 SHALL have port bank_return_flatted_in, input, NUM_BANK*W, bank return packets.
REQ-013 SHALL have port bank_return_ack_flatted_out, output, NUM_BANK, one-cycle consume pulse per bank.
REQ-014 SHALL have port return_flatted_out, output, NUM_INPUT_PORT*W, registered return packet per port.
REQ-015 SHALL have port return_ack_flatted_in, input, NUM_INPUT_PORT, requester consumed its return packet.

Function
REQ-016 SHALL treat a packet as valid iff bit `UNIFIED_CACHE_PACKET_VALID_POS is 1; all valid flags are in-band.
REQ-017 SHALL capture a valid request into its port FIFO and pulse request_ack the same cycle iff that FIFO is not full; a full FIFO gives no ack, even while popping.
REQ-018 SHALL derive the target bank from address bits [`UNIFIED_CACHE_PACKET_ADDR_POS_LO + BLOCK_OFFSET_WIDTH +: log2(NUM_BANK)].
REQ-019 SHALL, per bank, arbitrate round-robin among ports whose FIFO head targets that bank; pointer advances to winner+1 mod NUM_INPUT_PORT only on grant.
REQ-020 SHALL load the winner into the bank output register when the register is empty or acked in the same cycle, and pop the winner's FIFO that cycle.
REQ-021 SHALL present a captured request at bank_request_flatted_out no earlier than 2 cycles after capture; this is the minimum latency.
REQ-022 SHALL hold a bank output packet stable until bank_request_ack; the valid bit drops after ack if nothing is reloaded.
REQ-023 SHALL, per requester port, arbitrate round-robin among banks whose valid return packet has bits [`UNIFIED_CACHE_PACKET_PORT_NUM_LO +: PORT_ID_WIDTH] equal to that port.
REQ-024 SHALL load the return winner into the port output register, with the same empty-or-acked rule as REQ-020, and pulse that bank's bank_return_ack in the load cycle.
REQ-025 SHALL preserve per-port, per-bank request order; a blocked head request SHALL block later requests from that port.
REQ-026 SHALL never acknowledge a return packet whose port field is at least NUM_INPUT_PORT; that packet stalls its bank's return path.

Reset
REQ-027 SHALL, while reset_in is high at a clock edge, empty all FIFOs, zero all round-robin pointers, and clear the valid bit of every output register.
REQ-028 SHALL drive every ack output to 0 during reset; reset mid-transfer discards in-flight packets with no ack.

Configuration
REQ-029 SHALL, with UNIFIED_CACHE_XBAR_CRITICAL_EN defined, give ports with a full FIFO priority over round-robin, lowest index first, without moving the pointer; without the macro, arbitration is pure round-robin.

Structure
REQ-030 SHALL put packet field positions and PORT_ID_WIDTH = $clog2(NUM_INPUT_PORT)+1 in the shared parameters.h.
REQ-031 SHALL reuse the existing fifo_queue for input FIFOs and add one sub-module, rr_arbiter (request vector in, one-hot grant out, pointer register), used for both directions.

Verification
REQ-032 SHALL cover: port0 sends addr 0x40 -> bank1 output valid at cycle 2 with identical payload; ack in cycle 3 clears it.
REQ-033 SHALL cover: ports 0 and 1 both target bank2 for 4 cycles, no critical -> grants alternate 0,1,0,1.
REQ-034 SHALL cover: bank0 ack held low, port0 sends 6 requests to bank0 -> 4 acked (FIFO depth) plus 1 in output register; the 6th gets no ack until the bank acks.
REQ-035 SHALL cover: banks 0 and 3 return simultaneously to port1 -> both delivered in consecutive loads, bank_return_ack pulsed once each; port0 sees nothing.
REQ-036 SHALL cover: with UNIFIED_CACHE_XBAR_CRITICAL_EN, port1 FIFO full, pointer at 0 -> port1 granted first; reset asserted mid-stream -> all outputs invalid the next cycle.

Source files
------------

// File: rtl/unified_cache_crossbar_pkg.sv
// Shared packet layout and sizing helpers for the unified cache crossbar.
//
// Packet layout (PACKET_WIDTH bits):
//   [63]    valid flag (in-band; a packet with this bit low is idle)
//   [62:48] requester port number (only the low port_id_width() bits are decoded)
//   [47:32] payload carried through untouched
//   [31:0]  address; the bank select sits BLOCK_OFFSET_WIDTH bits above bit 0
package unified_cache_crossbar_pkg;

  localparam int PACKET_WIDTH       = 64;
  localparam int PACKET_VALID_POS   = 63;
  localparam int PACKET_ADDR_POS_LO = 0;
  localparam int PACKET_PORT_NUM_LO = 48;

  // One spare bit above the port index so that out-of-range port numbers
  // remain representable and can be rejected instead of aliasing a real port.
  function automatic int port_id_width(input int num_port);
    return $clog2(num_port) + 1;
  endfunction

endpackage

// File: rtl/unified_cache_crossbar_rr_arbiter.sv
// Round-robin arbiter with one-hot grant and an internal pointer register.
// Used for both directions of the crossbar.
//
// Build option: UNIFIED_CACHE_XBAR_CRITICAL_EN -- when defined, requesters
// flagged in prio_in win ahead of the round-robin order (lowest index first)
// and such a win leaves the pointer where it is.
//
// Ports:
//   clk_in, reset_in : clock and synchronous active-high reset
//   req_in           : requesting agents
//   prio_in          : critical-priority flags (ignored without the macro)
//   advance_in       : the granted request is actually taken this cycle
//   grant_out        : one-hot grant, zero when nobody requests
module unified_cache_crossbar_rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk_in,
  input  logic         reset_in,
  input  logic [N-1:0] req_in,
  input  logic [N-1:0] prio_in,
  input  logic         advance_in,
  output logic [N-1:0] grant_out
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d, win_idx;
  logic          found, crit_win;

`ifndef UNIFIED_CACHE_XBAR_CRITICAL_EN
  logic unused_prio;
  assign unused_prio = ^prio_in;
`endif

  always_comb begin
    found     = 1'b0;
    crit_win  = 1'b0;
    win_idx   = '0;
    grant_out = '0;
`ifdef UNIFIED_CACHE_XBAR_CRITICAL_EN
    for (int i = 0; i < N; i++) begin
      if (!found && req_in[i] && prio_in[i]) begin
        found    = 1'b1;
        crit_win = 1'b1;
        win_idx  = PW'(i);
      end
    end
`endif
    // Search starts at the pointer and wraps, so the last winner goes last.
    for (int i = 0; i < N; i++) begin
      if (!found && req_in[(int'(ptr_q) + i) % N]) begin
        found   = 1'b1;
        win_idx = PW'((int'(ptr_q) + i) % N);
      end
    end
    if (found) grant_out[win_idx] = 1'b1;
    ptr_d = ptr_q;
    if (advance_in && found && !crit_win) ptr_d = PW'((int'(win_idx) + 1) % N);
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/unified_cache_crossbar.sv
// Unified cache crossbar: per-port request FIFOs feeding registered bank
// outputs through per-bank round-robin arbiters, and registered per-port
// return outputs fed from the banks through per-port round-robin arbiters.
//
// Build option: UNIFIED_CACHE_XBAR_CRITICAL_EN -- ports whose request FIFO is
// full are served ahead of round-robin order (see the arbiter).
//
// Ports (W = UNIFIED_CACHE_PACKET_WIDTH_IN_BITS, slice k at [k*W +: W]):
//   clk_in, reset_in            : clock, synchronous active-high reset
//   request_flatted_in          : requester packets, one per port
//   request_ack_flatted_out     : capture pulse per port
//   bank_request_flatted_out    : registered packet per bank
//   bank_request_ack_flatted_in : bank consumed its packet
//   bank_return_flatted_in      : return packets, one per bank
//   bank_return_ack_flatted_out : consume pulse per bank
//   return_flatted_out          : registered return packet per port
//   return_ack_flatted_in       : requester consumed its return packet
module unified_cache_crossbar
  import unified_cache_crossbar_pkg::*;
#(
  parameter int NUM_INPUT_PORT                     = 2,
  parameter int NUM_BANK                           = 4,
  parameter int UNIFIED_CACHE_PACKET_WIDTH_IN_BITS = PACKET_WIDTH,
  parameter int QUEUE_DEPTH                        = 4,
  parameter int BLOCK_OFFSET_WIDTH                 = 6
) (
  input  logic                                                   clk_in,
  input  logic                                                   reset_in,
  input  logic [NUM_INPUT_PORT*UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] request_flatted_in,
  output logic [NUM_INPUT_PORT-1:0]                              request_ack_flatted_out,
  output logic [NUM_BANK*UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] bank_request_flatted_out,
  input  logic [NUM_BANK-1:0]                                    bank_request_ack_flatted_in,
  input  logic [NUM_BANK*UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] bank_return_flatted_in,
  output logic [NUM_BANK-1:0]                                    bank_return_ack_flatted_out,
  output logic [NUM_INPUT_PORT*UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] return_flatted_out,
  input  logic [NUM_INPUT_PORT-1:0]                              return_ack_flatted_in
);

  localparam int W           = UNIFIED_CACHE_PACKET_WIDTH_IN_BITS;
  localparam int V           = PACKET_VALID_POS;
  localparam int BANK_SEL_W  = $clog2(NUM_BANK);
  localparam int BANK_SEL_LO = PACKET_ADDR_POS_LO + BLOCK_OFFSET_WIDTH;
  localparam int PORT_ID_W   = port_id_width(NUM_INPUT_PORT);
  localparam int QPW         = $clog2(QUEUE_DEPTH);
  localparam int CNT_W       = QPW + 1;

  logic [W-1:0]     fifo_mem_q [NUM_INPUT_PORT][QUEUE_DEPTH];
  logic [W-1:0]     fifo_mem_d [NUM_INPUT_PORT][QUEUE_DEPTH];
  logic [QPW-1:0]   wr_ptr_q [NUM_INPUT_PORT], wr_ptr_d [NUM_INPUT_PORT];
  logic [QPW-1:0]   rd_ptr_q [NUM_INPUT_PORT], rd_ptr_d [NUM_INPUT_PORT];
  logic [CNT_W-1:0] count_q  [NUM_INPUT_PORT], count_d  [NUM_INPUT_PORT];
  logic [W-1:0]     bank_out_q [NUM_BANK], bank_out_d [NUM_BANK];
  logic [W-1:0]     ret_out_q [NUM_INPUT_PORT], ret_out_d [NUM_INPUT_PORT];

  logic [W-1:0] req_pkt [NUM_INPUT_PORT];
  logic [W-1:0] head    [NUM_INPUT_PORT];
  logic [W-1:0] ret_pkt [NUM_BANK];

  logic [NUM_INPUT_PORT-1:0] head_valid, fifo_full, push, pop, ret_load_ok;
  logic [NUM_BANK-1:0]       bank_load_ok, bank_ret_ack;
  logic [NUM_BANK-1:0][NUM_INPUT_PORT-1:0] bank_req, bank_grant;
  logic [NUM_INPUT_PORT-1:0][NUM_BANK-1:0] ret_req, ret_grant;

  always_comb begin
    head_valid   = '0;
    fifo_full    = '0;
    push         = '0;
    ret_load_ok  = '0;
    bank_load_ok = '0;
    bank_req     = '0;
    ret_req      = '0;
    req_pkt      = '{default: '0};
    head         = '{default: '0};
    ret_pkt      = '{default: '0};
    for (int p = 0; p < NUM_INPUT_PORT; p++) begin
      req_pkt[p]     = request_flatted_in[p*W +: W];
      head[p]        = fifo_mem_q[p][rd_ptr_q[p]];
      head_valid[p]  = count_q[p] != '0;
      // A full FIFO refuses capture even if it pops in the same cycle.
      fifo_full[p]   = count_q[p] == CNT_W'(QUEUE_DEPTH);
      push[p]        = req_pkt[p][V] && !fifo_full[p];
      ret_load_ok[p] = !ret_out_q[p][V] || return_ack_flatted_in[p];
    end
    for (int b = 0; b < NUM_BANK; b++) begin
      ret_pkt[b]      = bank_return_flatted_in[b*W +: W];
      bank_load_ok[b] = !bank_out_q[b][V] || bank_request_ack_flatted_in[b];
    end
    for (int b = 0; b < NUM_BANK; b++)
      for (int p = 0; p < NUM_INPUT_PORT; p++)
        bank_req[b][p] = head_valid[p] &&
                         head[p][BANK_SEL_LO +: BANK_SEL_W] == BANK_SEL_W'(b);
    // Out-of-range port numbers match no port, so that bank's return stalls.
    for (int p = 0; p < NUM_INPUT_PORT; p++)
      for (int b = 0; b < NUM_BANK; b++)
        ret_req[p][b] = ret_pkt[b][V] &&
                        ret_pkt[b][PACKET_PORT_NUM_LO +: PORT_ID_W] == PORT_ID_W'(p);
  end

  for (genvar gb = 0; gb < NUM_BANK; gb++) begin : g_bank_arb
    unified_cache_crossbar_rr_arbiter #(.N(NUM_INPUT_PORT)) u_arb (
      .clk_in    (clk_in),
      .reset_in  (reset_in),
      .req_in    (bank_req[gb]),
      .prio_in   (fifo_full),
      .advance_in(bank_load_ok[gb]),
      .grant_out (bank_grant[gb])
    );
  end

  for (genvar gp = 0; gp < NUM_INPUT_PORT; gp++) begin : g_ret_arb
    unified_cache_crossbar_rr_arbiter #(.N(NUM_BANK)) u_arb (
      .clk_in    (clk_in),
      .reset_in  (reset_in),
      .req_in    (ret_req[gp]),
      .prio_in   ('0),
      .advance_in(ret_load_ok[gp]),
      .grant_out (ret_grant[gp])
    );
  end

  always_comb begin
    fifo_mem_d   = fifo_mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    bank_out_d   = bank_out_q;
    ret_out_d    = ret_out_q;
    pop          = '0;
    bank_ret_ack = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      if (bank_request_ack_flatted_in[b]) bank_out_d[b][V] = 1'b0;
      for (int p = 0; p < NUM_INPUT_PORT; p++) begin
        if (bank_load_ok[b] && bank_grant[b][p]) begin
          bank_out_d[b] = head[p];
          pop[p]        = 1'b1;
        end
      end
    end
    for (int p = 0; p < NUM_INPUT_PORT; p++) begin
      if (return_ack_flatted_in[p]) ret_out_d[p][V] = 1'b0;
      for (int b = 0; b < NUM_BANK; b++) begin
        if (ret_load_ok[p] && ret_grant[p][b]) begin
          ret_out_d[p]    = ret_pkt[b];
          bank_ret_ack[b] = 1'b1;
        end
      end
      if (push[p]) begin
        fifo_mem_d[p][wr_ptr_q[p]] = req_pkt[p];
        wr_ptr_d[p] = wr_ptr_q[p] + 1'b1;
      end
      if (pop[p]) rd_ptr_d[p] = rd_ptr_q[p] + 1'b1;
      count_d[p] = count_q[p] + CNT_W'(push[p]) - CNT_W'(pop[p]);
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      for (int p = 0; p < NUM_INPUT_PORT; p++) begin
        wr_ptr_q[p]  <= '0;
        rd_ptr_q[p]  <= '0;
        count_q[p]   <= '0;
        ret_out_q[p] <= '0;
      end
      for (int b = 0; b < NUM_BANK; b++) bank_out_q[b] <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ret_out_q  <= ret_out_d;
      bank_out_q <= bank_out_d;
    end
  end

  // Storage needs no reset: entries are only read when the count says so.
  always_ff @(posedge clk_in) fifo_mem_q <= fifo_mem_d;

  always_comb begin
    request_ack_flatted_out     = reset_in ? '0 : push;
    bank_return_ack_flatted_out = reset_in ? '0 : bank_ret_ack;
    bank_request_flatted_out    = '0;
    return_flatted_out          = '0;
    for (int b = 0; b < NUM_BANK; b++) bank_request_flatted_out[b*W +: W] = bank_out_q[b];
    for (int p = 0; p < NUM_INPUT_PORT; p++) return_flatted_out[p*W +: W] = ret_out_q[p];
  end

endmodule

// File: tb/tb_unified_cache_crossbar.sv
module tb_unified_cache_crossbar;

  localparam int NP = 2;
  localparam int NB = 4;
  localparam int W  = 64;

  logic            clk_in = 1'b0;
  logic            reset_in;
  logic [NP*W-1:0] request_flatted_in;
  logic [NP-1:0]   request_ack_flatted_out;
  logic [NB*W-1:0] bank_request_flatted_out;
  logic [NB-1:0]   bank_request_ack_flatted_in;
  logic [NB*W-1:0] bank_return_flatted_in;
  logic [NB-1:0]   bank_return_ack_flatted_out;
  logic [NP*W-1:0] return_flatted_out;
  logic [NP-1:0]   return_ack_flatted_in;

  logic [W-1:0] req_pkt [NP];
  logic [W-1:0] ret_pkt [NB];

  int n_checks = 0;
  int n_fail   = 0;

  for (genvar g = 0; g < NP; g++) begin : g_req
    assign request_flatted_in[g*W +: W] = req_pkt[g];
  end
  for (genvar g = 0; g < NB; g++) begin : g_ret
    assign bank_return_flatted_in[g*W +: W] = ret_pkt[g];
  end

  unified_cache_crossbar dut (
    .clk_in                     (clk_in),
    .reset_in                   (reset_in),
    .request_flatted_in         (request_flatted_in),
    .request_ack_flatted_out    (request_ack_flatted_out),
    .bank_request_flatted_out   (bank_request_flatted_out),
    .bank_request_ack_flatted_in(bank_request_ack_flatted_in),
    .bank_return_flatted_in     (bank_return_flatted_in),
    .bank_return_ack_flatted_out(bank_return_ack_flatted_out),
    .return_flatted_out         (return_flatted_out),
    .return_ack_flatted_in      (return_ack_flatted_in)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] mk(input logic [31:0] addr, input logic [15:0] data,
                                     input logic [14:0] port);
    return {1'b1, port, data, addr};
  endfunction

  function automatic logic [63:0] bank_pkt(input int b);
    return bank_request_flatted_out[b*W +: W];
  endfunction

  function automatic logic [63:0] ret_out(input int p);
    return return_flatted_out[p*W +: W];
  endfunction

  function automatic logic [NB-1:0] bank_valid();
    logic [NB-1:0] v;
    for (int b = 0; b < NB; b++) v[b] = bank_request_flatted_out[b*W + 63];
    return v;
  endfunction

  function automatic logic [NP-1:0] ret_valid();
    logic [NP-1:0] v;
    for (int p = 0; p < NP; p++) v[p] = return_flatted_out[p*W + 63];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive_idle();
    for (int p = 0; p < NP; p++) req_pkt[p] = '0;
    for (int b = 0; b < NB; b++) ret_pkt[b] = '0;
    bank_request_ack_flatted_in = '0;
    return_ack_flatted_in       = '0;
  endtask

  task automatic do_reset();
    reset_in = 1'b1;
    drive_idle();
    next_cycle();
    next_cycle();
    reset_in = 1'b0;
  endtask

  initial begin
    reset_in = 1'b1;
    drive_idle();

    // Reset: acks stay low even with live inputs, outputs invalid.
    req_pkt[0] = mk(32'h40, 16'h0001, 15'd0);
    ret_pkt[0] = mk(32'h0, 16'h0002, 15'd0);
    next_cycle();
    @(negedge clk_in);
    chk("rst_req_ack", 64'(request_ack_flatted_out), 64'h0);
    chk("rst_ret_ack", 64'(bank_return_ack_flatted_out), 64'h0);
    chk("rst_bank_v", 64'(bank_valid()), 64'h0);
    chk("rst_ret_v", 64'(ret_valid()), 64'h0);

    // Single request to bank1: visible two cycles after capture, held until ack.
    do_reset();
    req_pkt[0] = mk(32'h40, 16'hA5A5, 15'd0);
    @(negedge clk_in);
    chk("t1_ack_c0", 64'(request_ack_flatted_out), 64'h1);
    next_cycle();
    req_pkt[0] = '0;
    @(negedge clk_in);
    chk("t1_bank_v_c1", 64'(bank_valid()), 64'h0);
    next_cycle();
    @(negedge clk_in);
    chk("t1_pkt_c2", bank_pkt(1), mk(32'h40, 16'hA5A5, 15'd0));
    chk("t1_bank_v_c2", 64'(bank_valid()), 64'h2);
    next_cycle();
    bank_request_ack_flatted_in = 4'b0010;
    @(negedge clk_in);
    chk("t1_pkt_c3", bank_pkt(1), mk(32'h40, 16'hA5A5, 15'd0));
    next_cycle();
    bank_request_ack_flatted_in = '0;
    @(negedge clk_in);
    chk("t1_bank_v_c4", 64'(bank_valid()), 64'h0);

    // Two ports contend for bank2 with the bank always ready: grants alternate.
    do_reset();
    bank_request_ack_flatted_in = 4'b0100;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        req_pkt[0] = mk(32'h80, 16'(k), 15'd0);
        req_pkt[1] = mk(32'h80, 16'(16'h0100 + k), 15'd1);
      end else begin
        req_pkt[0] = '0;
        req_pkt[1] = '0;
      end
      @(negedge clk_in);
      if (k < 4) chk($sformatf("t2_ack_c%0d", k), 64'(request_ack_flatted_out), 64'h3);
      if (k >= 2)
        chk($sformatf("t2_pkt_c%0d", k), bank_pkt(2),
            mk(32'h80, 16'(((k - 2) % 2) * 256 + (k - 2) / 2), 15'((k - 2) % 2)));
      next_cycle();
    end

    // Bank0 stalled: four in the FIFO plus one in the output register, sixth waits.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      bank_request_ack_flatted_in = (k == 7) ? 4'b0001 : 4'b0000;
      req_pkt[0] = mk(32'h100, 16'(16'h0200 + ((k < 6) ? k : 5)), 15'd0);
      @(negedge clk_in);
      chk($sformatf("t3_ack_c%0d", k), 64'(request_ack_flatted_out[0]),
          64'((k < 5) || (k == 8)));
      if (k == 7) chk("t3_pkt_c7", bank_pkt(0), mk(32'h100, 16'h0200, 15'd0));
      if (k == 8) chk("t3_pkt_c8", bank_pkt(0), mk(32'h100, 16'h0201, 15'd0));
      next_cycle();
    end

    // Banks 0 and 3 return to port1 together: consecutive loads, one ack each.
    do_reset();
    return_ack_flatted_in = 2'b11;
    ret_pkt[0] = mk(32'h0, 16'h00B0, 15'd1);
    ret_pkt[3] = mk(32'h0, 16'h00B3, 15'd1);
    @(negedge clk_in);
    chk("t4_rack_c0", 64'(bank_return_ack_flatted_out), 64'h1);
    chk("t4_rv_c0", 64'(ret_valid()), 64'h0);
    next_cycle();
    ret_pkt[0] = '0;
    @(negedge clk_in);
    chk("t4_rack_c1", 64'(bank_return_ack_flatted_out), 64'h8);
    chk("t4_ret1_c1", ret_out(1), mk(32'h0, 16'h00B0, 15'd1));
    chk("t4_rv0_c1", 64'(ret_valid()), 64'h2);
    next_cycle();
    ret_pkt[3] = '0;
    @(negedge clk_in);
    chk("t4_rack_c2", 64'(bank_return_ack_flatted_out), 64'h0);
    chk("t4_ret1_c2", ret_out(1), mk(32'h0, 16'h00B3, 15'd1));
    chk("t4_rv_c2", 64'(ret_valid()), 64'h2);
    next_cycle();
    @(negedge clk_in);
    chk("t4_rv_c3", 64'(ret_valid()), 64'h0);

    // Out-of-range port number is never acked; a legal neighbour still flows.
    do_reset();
    return_ack_flatted_in = 2'b11;
    ret_pkt[2] = mk(32'h0, 16'h00EE, 15'd2);
    ret_pkt[1] = mk(32'h0, 16'h0011, 15'd0);
    @(negedge clk_in);
    chk("t5_rack_c0", 64'(bank_return_ack_flatted_out), 64'h2);
    next_cycle();
    ret_pkt[1] = '0;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk_in);
      chk($sformatf("t5_rack_c%0d", k), 64'(bank_return_ack_flatted_out), 64'h0);
      if (k == 1) chk("t5_ret0_c1", ret_out(0), mk(32'h0, 16'h0011, 15'd0));
      else        chk($sformatf("t5_rv_c%0d", k), 64'(ret_valid()), 64'h0);
      next_cycle();
    end

    // Reset in the middle of traffic discards everything without acks.
    do_reset();
    req_pkt[0] = mk(32'h40, 16'h0055, 15'd0);
    req_pkt[1] = mk(32'hC0, 16'h0066, 15'd1);
    ret_pkt[0] = mk(32'h0, 16'h0077, 15'd0);
    next_cycle();
    req_pkt[0] = '0;
    req_pkt[1] = '0;
    ret_pkt[0] = '0;
    next_cycle();
    @(negedge clk_in);
    chk("t6_bank_v_pre", 64'(bank_valid()), 64'hA);
    chk("t6_rv_pre", 64'(ret_valid()), 64'h1);
    reset_in   = 1'b1;
    req_pkt[0] = mk(32'h40, 16'h0088, 15'd0);
    ret_pkt[1] = mk(32'h0, 16'h0099, 15'd0);
    next_cycle();
    @(negedge clk_in);
    chk("t6_bank_v_rst", 64'(bank_valid()), 64'h0);
    chk("t6_rv_rst", 64'(ret_valid()), 64'h0);
    chk("t6_req_ack_rst", 64'(request_ack_flatted_out), 64'h0);
    chk("t6_rack_rst", 64'(bank_return_ack_flatted_out), 64'h0);
    next_cycle();
    reset_in = 1'b0;
    drive_idle();
    next_cycle();
    next_cycle();
    @(negedge clk_in);
    chk("t6_bank_v_post", 64'(bank_valid()), 64'h0);

`ifdef UNIFIED_CACHE_XBAR_CRITICAL_EN
    // Port1 FIFO full with the bank3 pointer at 0: port1 wins, pointer stays.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      req_pkt[1] = mk(32'hC0, 16'(16'h0300 + k), 15'd1);
      req_pkt[0] = (k == 4) ? mk(32'hC0, 16'h0400, 15'd0) : 64'h0;
      @(negedge clk_in);
      chk($sformatf("t7_ack_c%0d", k), 64'(request_ack_flatted_out), (k == 4) ? 64'h3 : 64'h2);
      next_cycle();
    end
    req_pkt[0] = '0;
    req_pkt[1] = '0;
    bank_request_ack_flatted_in = 4'b1000;
    @(negedge clk_in);
    chk("t7_pkt_c5", bank_pkt(3), mk(32'hC0, 16'h0300, 15'd1));
    next_cycle();
    @(negedge clk_in);
    chk("t7_pkt_c6", bank_pkt(3), mk(32'hC0, 16'h0301, 15'd1));
    next_cycle();
    bank_request_ack_flatted_in = '0;
    @(negedge clk_in);
    chk("t7_pkt_c7", bank_pkt(3), mk(32'hC0, 16'h0400, 15'd0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
